// File: rtl/pong_pkg.sv
// Shared Pong definitions: screen/paddle geometry, ball FSM states and
// direction encoding, used by the ball, paddle control and renderer blocks.
package pong_pkg;

   localparam logic [9:0] H_ACTIVE   = 10'd640;
   localparam logic [9:0] V_ACTIVE   = 10'd480;
   localparam logic [9:0] BALL_SIZE  = 10'd8;
   localparam logic [9:0] PADDLE_H   = 10'd64;
   localparam logic [9:0] PADDLE_W   = 10'd8;
   localparam logic [9:0] PADDLE_L_X = 10'd16;
   localparam logic [9:0] PADDLE_R_X = 10'd616;
   localparam logic [9:0] SPEED      = 10'd2;

   localparam logic [9:0] CENTRE_X   = (H_ACTIVE - BALL_SIZE) >> 1;
   localparam logic [9:0] CENTRE_Y   = (V_ACTIVE - BALL_SIZE) >> 1;

   localparam int         SERVE_DELAY = 60;
   localparam logic [5:0] SERVE_LAST  = 6'(SERVE_DELAY - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      MOVE   = 2'd1,
      SCORED = 2'd2
   } state_e;

   // INC means right on x and down on y.
   typedef enum logic {
      DIR_INC = 1'b0,
      DIR_DEC = 1'b1
   } dir_e;

   // Vertical overlap of ball and paddle; 11-bit so pad_y + PADDLE_H cannot wrap.
   function automatic logic paddle_overlap(input logic [9:0] ball_y,
                                           input logic [9:0] pad_y);
      return (({1'b0, ball_y} + {1'b0, BALL_SIZE}) > {1'b0, pad_y}) &&
             ({1'b0, ball_y} < ({1'b0, pad_y} + {1'b0, PADDLE_H}));
   endfunction

endpackage

// File: rtl/ball_motion.sv
// Pong ball: one step per 60 Hz tick with wall bounces, paddle hits,
// miss scoring and the serve/recentre sequence.
module ball_motion
   import pong_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       ref_tick,
   input  logic       serve,
   input  logic [9:0] paddle_l_y,
   input  logic [9:0] paddle_r_y,
   output logic [9:0] ball_x,
   output logic [9:0] ball_y,
   output logic       score_l,
   output logic       score_r,
   output logic       in_play
);

   state_e     state_q, state_d;
   dir_e       dx_q, dx_d, dy_q, dy_d;
   logic [9:0] x_q, x_d, y_q, y_d;
   logic       score_l_q, score_l_d, score_r_q, score_r_d;
   logic [5:0] tick_cnt_q, tick_cnt_d;
   logic       overlap_l, overlap_r;

   assign overlap_l = paddle_overlap(y_q, paddle_l_y);
   assign overlap_r = paddle_overlap(y_q, paddle_r_y);

   always_comb begin
      state_d    = state_q;
      x_d        = x_q;
      y_d        = y_q;
      dx_d       = dx_q;
      dy_d       = dy_q;
      score_l_d  = 1'b0;
      score_r_d  = 1'b0;
      tick_cnt_d = tick_cnt_q;

      case (state_q)
         // ref_tick is a single-cycle strobe; serve is a level sampled only here.
         IDLE: begin
            if (serve) state_d = MOVE;
         end

         MOVE: begin
            if (ref_tick) begin
               if (dy_q == DIR_INC) begin
                  if (y_q + BALL_SIZE + SPEED >= V_ACTIVE) begin
                     y_d  = V_ACTIVE - BALL_SIZE;
                     dy_d = DIR_DEC;
                  end else begin
                     y_d = y_q + SPEED;
                  end
               end else begin
                  if (y_q <= SPEED) begin
                     y_d  = '0;
                     dy_d = DIR_INC;
                  end else begin
                     y_d = y_q - SPEED;
                  end
               end

               // A miss leaves dx pointing at the conceding side for the next serve.
               if (dx_q == DIR_INC) begin
                  if ((x_q <= PADDLE_R_X - BALL_SIZE) &&
                      (x_q + BALL_SIZE + SPEED >= PADDLE_R_X) && overlap_r) begin
                     x_d  = PADDLE_R_X - BALL_SIZE;
                     dx_d = DIR_DEC;
                  end else if (x_q + BALL_SIZE + SPEED >= H_ACTIVE) begin
                     score_l_d = 1'b1;
                     state_d   = SCORED;
                     dx_d      = DIR_INC;
                  end else begin
                     x_d = x_q + SPEED;
                  end
               end else begin
                  if ((x_q >= PADDLE_L_X + PADDLE_W) &&
                      (x_q <= PADDLE_L_X + PADDLE_W + SPEED) && overlap_l) begin
                     x_d  = PADDLE_L_X + PADDLE_W;
                     dx_d = DIR_INC;
                  end else if (x_q <= SPEED) begin
                     score_r_d = 1'b1;
                     state_d   = SCORED;
                     dx_d      = DIR_DEC;
                  end else begin
                     x_d = x_q - SPEED;
                  end
               end
            end
         end

         SCORED: begin
            if (ref_tick) begin
               if (tick_cnt_q == SERVE_LAST) begin
                  tick_cnt_d = '0;
                  x_d        = CENTRE_X;
                  y_d        = CENTRE_Y;
                  dy_d       = DIR_INC;
                  state_d    = IDLE;
               end else begin
                  tick_cnt_d = tick_cnt_q + 6'd1;
               end
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         x_q        <= CENTRE_X;
         y_q        <= CENTRE_Y;
         dx_q       <= DIR_INC;
         dy_q       <= DIR_INC;
         score_l_q  <= 1'b0;
         score_r_q  <= 1'b0;
         tick_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         x_q        <= x_d;
         y_q        <= y_d;
         dx_q       <= dx_d;
         dy_q       <= dy_d;
         score_l_q  <= score_l_d;
         score_r_q  <= score_r_d;
         tick_cnt_q <= tick_cnt_d;
      end
   end

   assign ball_x  = x_q;
   assign ball_y  = y_q;
   assign score_l = score_l_q;
   assign score_r = score_r_q;
   assign in_play = (state_q == MOVE);

endmodule

// File: tb/tb_ball_motion.sv
// Bench for ball_motion: checkpoint tables along long flights plus
// hand-written reset, serve/tick collision and scoring sequences.
module tb_ball_motion;

   logic       clk = 1'b0;
   logic       rst;
   logic       ref_tick;
   logic       serve;
   logic [9:0] paddle_l_y;
   logic [9:0] paddle_r_y;
   logic [9:0] ball_x;
   logic [9:0] ball_y;
   logic       score_l;
   logic       score_r;
   logic       in_play;

   ball_motion dut (
      .clk        (clk),
      .rst        (rst),
      .ref_tick   (ref_tick),
      .serve      (serve),
      .paddle_l_y (paddle_l_y),
      .paddle_r_y (paddle_r_y),
      .ball_x     (ball_x),
      .ball_y     (ball_y),
      .score_l    (score_l),
      .score_r    (score_r),
      .in_play    (in_play)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [22:0] exp_q[$];

   typedef struct {
      int         tick;
      logic [9:0] x;
      logic [9:0] y;
      logic       sl;
      logic       sr;
      logic       ip;
   } vec_t;

   vec_t tbl[$];

   function automatic logic [22:0] pk(input logic [9:0] x, input logic [9:0] y,
                                      input logic sl, input logic sr, input logic ip);
      return {x, y, sl, sr, ip};
   endfunction

   task automatic check_pop(input string name);
      logic [22:0] got;
      logic [22:0] exp;
      got = {ball_x, ball_y, score_l, score_r, in_play};
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL %s: scoreboard empty, got x=%0d y=%0d", name, got[22:13], got[12:3]);
      end else begin
         exp = exp_q.pop_front();
         if (got !== exp) begin
            errors++;
            $display("FAIL %s: got x=%0d y=%0d sl=%0b sr=%0b ip=%0b, expected x=%0d y=%0d sl=%0b sr=%0b ip=%0b",
                     name, got[22:13], got[12:3], got[2], got[1], got[0],
                     exp[22:13], exp[12:3], exp[2], exp[1], exp[0]);
         end
      end
   endtask

   task automatic expect_now(input string name, input logic [9:0] x, input logic [9:0] y,
                             input logic sl, input logic sr, input logic ip);
      exp_q.push_back(pk(x, y, sl, sr, ip));
      check_pop(name);
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic tick();
      ref_tick = 1'b1;
      cycle();
      ref_tick = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cycle();
      cycle();
      rst = 1'b0;
   endtask

   task automatic serve_pulse();
      serve = 1'b1;
      cycle();
      serve = 1'b0;
   endtask

   // Ticks 1..n_ticks; entries of tbl are checked the cycle after their tick.
   task automatic run_flight(input int n_ticks, input string tag);
      int idx;
      bit hit;
      idx = 0;
      for (int t = 1; t <= n_ticks; t++) begin
         hit = (idx < tbl.size()) && (tbl[idx].tick == t);
         if (hit && t == 10) begin
            ref_tick = 1'b1;
            @(negedge clk);
            expect_now({tag, "_latency_pre"}, 10'd334, 10'd254, 1'b0, 1'b0, 1'b1);
            exp_q.push_back(pk(tbl[idx].x, tbl[idx].y, tbl[idx].sl, tbl[idx].sr, tbl[idx].ip));
            @(posedge clk);
            #1;
            ref_tick = 1'b0;
         end else begin
            if (hit) exp_q.push_back(pk(tbl[idx].x, tbl[idx].y, tbl[idx].sl, tbl[idx].sr, tbl[idx].ip));
            tick();
         end
         if (hit) begin
            check_pop($sformatf("%s_tick%0d", tag, t));
            idx++;
         end
      end
   endtask

   // After a miss: pulse drops, ball frozen for 59 ticks, recentred on the 60th.
   task automatic scored_wait(input string tag, input logic [9:0] fx, input logic [9:0] fy);
      cycle();
      expect_now({tag, "_pulse_end"}, fx, fy, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 59; i++) tick();
      expect_now({tag, "_frozen"}, fx, fy, 1'b0, 1'b0, 1'b0);
      tick();
      expect_now({tag, "_recentre"}, 10'd316, 10'd236, 1'b0, 1'b0, 1'b0);
      tick();
      expect_now({tag, "_idle_tick"}, 10'd316, 10'd236, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst        = 1'b1;
      ref_tick   = 1'b0;
      serve      = 1'b0;
      paddle_l_y = 10'd0;
      paddle_r_y = 10'd400;

      do_reset();
      expect_now("reset", 10'd316, 10'd236, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) tick();
      expect_now("idle_ticks", 10'd316, 10'd236, 1'b0, 1'b0, 1'b0);

      // Flight 1: bottom bounce, right paddle hit, top bounce, left miss.
      serve_pulse();
      expect_now("f1_serve", 10'd316, 10'd236, 1'b0, 1'b0, 1'b1);
      tbl.delete();
      tbl.push_back('{1,   10'd318, 10'd238, 1'b0, 1'b0, 1'b1});
      tbl.push_back('{10,  10'd336, 10'd256, 1'b0, 1'b0, 1'b1});
      tbl.push_back('{117, 10'd550, 10'd470, 1'b0, 1'b0, 1'b1});
      tbl.push_back('{118, 10'd552, 10'd472, 1'b0, 1'b0, 1'b1});
      tbl.push_back('{119, 10'd554, 10'd470, 1'b0, 1'b0, 1'b1});
      tbl.push_back('{145, 10'd606, 10'd418, 1'b0, 1'b0, 1'b1});
      tbl.push_back('{146, 10'd608, 10'd416, 1'b0, 1'b0, 1'b1});
      tbl.push_back('{147, 10'd606, 10'd414, 1'b0, 1'b0, 1'b1});
      tbl.push_back('{353, 10'd194, 10'd2,   1'b0, 1'b0, 1'b1});
      tbl.push_back('{354, 10'd192, 10'd0,   1'b0, 1'b0, 1'b1});
      tbl.push_back('{355, 10'd190, 10'd2,   1'b0, 1'b0, 1'b1});
      tbl.push_back('{438, 10'd24,  10'd168, 1'b0, 1'b0, 1'b1});
      tbl.push_back('{449, 10'd2,   10'd190, 1'b0, 1'b0, 1'b1});
      tbl.push_back('{450, 10'd2,   10'd192, 1'b0, 1'b1, 1'b0});
      run_flight(450, "f1");
      scored_wait("f1", 10'd2, 10'd192);
      serve_pulse();
      tick();
      expect_now("f1_reserve_left", 10'd314, 10'd238, 1'b0, 1'b0, 1'b1);

      // Flight 2: right paddle out of the way, right miss.
      do_reset();
      paddle_r_y = 10'd0;
      serve_pulse();
      tbl.delete();
      tbl.push_back('{1,   10'd318, 10'd238, 1'b0, 1'b0, 1'b1});
      tbl.push_back('{146, 10'd608, 10'd416, 1'b0, 1'b0, 1'b1});
      tbl.push_back('{157, 10'd630, 10'd394, 1'b0, 1'b0, 1'b1});
      tbl.push_back('{158, 10'd630, 10'd392, 1'b1, 1'b0, 1'b0});
      run_flight(158, "f2");
      scored_wait("f2", 10'd630, 10'd392);
      serve_pulse();
      tick();
      expect_now("f2_reserve_right", 10'd318, 10'd238, 1'b0, 1'b0, 1'b1);

      // Flight 3: left paddle placed to return the ball.
      do_reset();
      paddle_r_y = 10'd400;
      paddle_l_y = 10'd160;
      serve_pulse();
      tbl.delete();
      tbl.push_back('{146, 10'd608, 10'd416, 1'b0, 1'b0, 1'b1});
      tbl.push_back('{438, 10'd24,  10'd168, 1'b0, 1'b0, 1'b1});
      tbl.push_back('{439, 10'd26,  10'd170, 1'b0, 1'b0, 1'b1});
      tbl.push_back('{440, 10'd28,  10'd172, 1'b0, 1'b0, 1'b1});
      run_flight(440, "f3");

      // Reset mid-flight with a tick pending, then serve and tick together.
      rst      = 1'b1;
      ref_tick = 1'b1;
      cycle();
      rst      = 1'b0;
      ref_tick = 1'b0;
      expect_now("mid_reset", 10'd316, 10'd236, 1'b0, 1'b0, 1'b0);
      serve    = 1'b1;
      ref_tick = 1'b1;
      cycle();
      serve    = 1'b0;
      ref_tick = 1'b0;
      expect_now("serve_tick_same", 10'd316, 10'd236, 1'b0, 1'b0, 1'b1);
      tick();
      expect_now("after_collision", 10'd318, 10'd238, 1'b0, 1'b0, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
